// File: rtl/lsu_mem_if.sv
// lsu_mem bus bundles: execute-side request/response
// and the data-memory req/ack port.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, opcode_in, funct3_in,
    output addr_in, store_data_in,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, opcode_in, funct3_in,
    input  addr_in, store_data_in,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

interface lsu_bus_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_wstrb,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lsu_mem.sv
// Load/store unit: executes one LOAD/STORE per request
// over a req/ack data-memory port with timeout.
module lsu_mem #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic      clk,
  input  logic      rst,
  lsu_req_if.slave  req,
  lsu_bus_if.master bus
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        is_store;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] data;
  logic [15:0] cnt;
  logic [31:0] res_data;
  logic        res_err;

  logic        accept;
  logic        in_load;
  logic        in_store;
  logic        in_misal;
  logic        in_illegal;
  logic        in_bad;
  logic        timeout;
  logic [31:0] load_val;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign accept   = req.req_valid & req.req_ready;
  assign in_load  = req.opcode_in == OP_LOAD;
  assign in_store = req.opcode_in == OP_STORE;
  assign timeout  = cnt == LIMIT;

  // Acceptance-time checks: alignment and funct3 legality.
  always_comb begin
    in_misal = 1'b0;
    in_illegal = 1'b0;
    unique case (req.funct3_in[1:0])
      2'b01:   in_misal = req.addr_in[0];
      2'b10:   in_misal = req.addr_in[1:0] != 2'b00;
      default: in_misal = 1'b0;
    endcase
    if (in_store)
      in_illegal = req.funct3_in >= 3'd3;
    else
      in_illegal = (req.funct3_in == 3'd3) |
                   (req.funct3_in[2:1] == 2'b11);
    in_bad = in_misal | in_illegal;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept & (in_load | in_store))
          state_nxt = in_bad ? RESP : ACCESS;
      end
      ACCESS: begin
        if (bus.mem_ack | timeout)
          state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Wait counter: zero outside ACCESS, counts ack-less cycles.
  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (state != ACCESS) cnt <= '0;
    else                      cnt <= cnt + 16'd1;
  end

  // Lane-replicated store data and byte enables.
  always_comb begin
    st_wdata = '0;
    st_wstrb = '0;
    unique case (f3)
      3'd0: begin
        st_wdata = {4{data[7:0]}};
        st_wstrb = 4'b0001 << addr[1:0];
      end
      3'd1: begin
        st_wdata = {2{data[15:0]}};
        st_wstrb = 4'b0011 << addr[1:0];
      end
      3'd2: begin
        st_wdata = data;
        st_wstrb = 4'b1111;
      end
      default: begin
        st_wdata = '0;
        st_wstrb = '0;
      end
    endcase
  end

  // Load lane select and sign/zero extension.
  always_comb begin
    rd_byte  = 8'(bus.mem_rdata >> {addr[1:0], 3'b000});
    rd_half  = addr[1] ? bus.mem_rdata[31:16]
                       : bus.mem_rdata[15:0];
    load_val = '0;
    unique case (f3)
      3'd0:    load_val = {{24{rd_byte[7]}}, rd_byte};
      3'd1:    load_val = {{16{rd_half[15]}}, rd_half};
      3'd2:    load_val = bus.mem_rdata;
      3'd4:    load_val = {24'd0, rd_byte};
      3'd5:    load_val = {16'd0, rd_half};
      default: load_val = '0;
    endcase
  end

  // Request latch and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_store <= 1'b0;
      f3       <= '0;
      addr     <= '0;
      data     <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else if (state == IDLE) begin
      if (accept & (in_load | in_store)) begin
        is_store <= in_store;
        f3       <= req.funct3_in;
        addr     <= req.addr_in;
        data     <= req.store_data_in;
        res_data <= '0;
        res_err  <= in_bad;
      end
    end else if (state == ACCESS) begin
      if (bus.mem_ack) begin
        res_data <= is_store ? 32'd0 : load_val;
        res_err  <= 1'b0;
      end else if (timeout) begin
        res_data <= '0;
        res_err  <= 1'b1;
      end
    end
  end

  // Outputs, forced to zero while reset is held.
  always_comb begin
    req.req_ready  = (state == IDLE) & ~rst;
    bus.mem_req    = (state == ACCESS) & ~rst;
    bus.mem_we     = bus.mem_req & is_store;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_wstrb  = '0;
    req.resp_valid = (state == RESP) & ~rst;
    req.resp_data  = '0;
    req.resp_err   = 1'b0;
    if (bus.mem_req) begin
      bus.mem_addr = {addr[31:2], 2'b00};
      if (is_store) begin
        bus.mem_wdata = st_wdata;
        bus.mem_wstrb = st_wstrb;
      end
    end
    if (req.resp_valid) begin
      req.resp_data = res_data;
      req.resp_err  = res_err;
    end
  end

endmodule

// File: tb/tb_lsu_mem.sv
// Self-checking bench for lsu_mem: directed cases
// plus randomized transactions against a reference model.
module tb_lsu_mem;

  localparam int TO = 4;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int pass = 0;
  int total = 0;

  lsu_req_if rif ();
  lsu_bus_if bif ();

  lsu_mem #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .req (rif),
    .bus (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    int          reqc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
    logic        we;
    logic        err;
    logic        stable;
    logic        rdy;
    logic [3:0]  wstrb;
  } obs_t;

  function automatic int sz(input logic [2:0] f);
    if (f[1:0] == 2'd0) return 1;
    if (f[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit m_bad(input bit st,
    input logic [2:0] f, input logic [31:0] a);
    if (st && f >= 3) return 1;
    if (!st && (f == 3 || f >= 6)) return 1;
    return (a % sz(f)) != 0;
  endfunction

  function automatic logic [3:0] m_wstrb(
    input logic [2:0] f, input logic [31:0] a);
    int m;
    m = ((1 << sz(f)) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] m_wdata(
    input logic [2:0] f, input logic [31:0] d);
    if (sz(f) == 1) return (d % 256) * 32'h01010101;
    if (sz(f) == 2) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(
    input logic [2:0] f, input logic [31:0] a,
    input logic [31:0] rd);
    longint v;
    longint span;
    int s;
    s = sz(f);
    span = longint'(1) << (8 * s);
    v = longint'(rd) / (longint'(1) << (8 * (a % 4)));
    v = v % span;
    if (f < 4 && s < 4 && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_txn(input logic [6:0] op,
    input logic [2:0] f, input logic [31:0] a,
    input logic [31:0] d, input int ack_after,
    input logic [31:0] rd, output obs_t o);
    int n;
    o = '{default: 0};
    o.stable = 1'b1;
    n = 0;
    while (rif.req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    bif.mem_rdata = rd;
    rif.req_valid = 1'b1;
    rif.opcode_in = op;
    rif.funct3_in = f;
    rif.addr_in = a;
    rif.store_data_in = d;
    tick();
    rif.req_valid = 1'b0;
    rif.addr_in = $urandom;
    rif.store_data_in = $urandom;
    for (int c = 1; c <= 40; c++) begin
      bif.mem_ack = 1'b0;
      if (bif.mem_req === 1'b1) begin
        if (o.reqc == 0) begin
          o.addr = bif.mem_addr;
          o.we = bif.mem_we;
          o.wdata = bif.mem_wdata;
          o.wstrb = bif.mem_wstrb;
        end else if (o.addr !== bif.mem_addr ||
                     o.we !== bif.mem_we ||
                     o.wdata !== bif.mem_wdata ||
                     o.wstrb !== bif.mem_wstrb) begin
          o.stable = 1'b0;
        end
        bif.mem_ack = (ack_after >= 0 &&
                       o.reqc == ack_after);
        o.reqc++;
      end
      if (rif.resp_valid === 1'b1) begin
        o.lat = c;
        o.data = rif.resp_data;
        o.err = rif.resp_err;
        tick();
        o.rdy = rif.req_ready;
        break;
      end
      tick();
    end
    bif.mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if (rif.req_ready !== 1'b0)
      $display("FAIL rst_ready got %b exp 0", rif.req_ready);
    else pass++;
    total++;
    if (bif.mem_req !== 1'b0 || rif.resp_valid !== 1'b0)
      $display("FAIL rst_outs req %b resp %b exp 0 0",
               bif.mem_req, rif.resp_valid);
    else pass++;
    total++;
    if (bif.mem_addr !== 32'd0 || rif.resp_data !== 32'd0)
      $display("FAIL rst_data addr %h rd %h exp 0",
               bif.mem_addr, rif.resp_data);
    else pass++;
    rst = 1'b0;
    tick();
    total++;
    if (rif.req_ready !== 1'b1)
      $display("FAIL rst_release got %b exp 1", rif.req_ready);
    else pass++;
  endtask

  task automatic test_store();
    obs_t o;
    run_txn(ST, 3'd2, 32'h100, 32'hDEADBEEF, 0, 32'h0, o);
    total++;
    if (o.addr !== 32'h100)
      $display("FAIL sw_addr got %h exp 00000100", o.addr);
    else pass++;
    total++;
    if (o.wstrb !== 4'b1111 || o.we !== 1'b1)
      $display("FAIL sw_strb got %b/%b exp 1111/1",
               o.wstrb, o.we);
    else pass++;
    total++;
    if (o.wdata !== 32'hDEADBEEF)
      $display("FAIL sw_wdata got %h exp deadbeef", o.wdata);
    else pass++;
    total++;
    if (o.lat != 2 || o.data !== 32'd0 || o.err !== 1'b0)
      $display("FAIL sw_resp lat %0d d %h e %b exp 2 0 0",
               o.lat, o.data, o.err);
    else pass++;
    total++;
    if (o.rdy !== 1'b1)
      $display("FAIL sw_ready got %b exp 1", o.rdy);
    else pass++;
    run_txn(ST, 3'd0, 32'h203, 32'h000000A5, 1, 32'h0, o);
    total++;
    if (o.addr !== 32'h200 || o.wstrb !== 4'b1000)
      $display("FAIL sb_lane got %h/%b exp 00000200/1000",
               o.addr, o.wstrb);
    else pass++;
    total++;
    if (o.wdata !== 32'hA5A5A5A5 || o.stable !== 1'b1)
      $display("FAIL sb_wdata got %h st %b exp a5a5a5a5 1",
               o.wdata, o.stable);
    else pass++;
  endtask

  task automatic test_load();
    obs_t o;
    logic [2:0]  fs [5] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] as [5] = '{32'h41, 32'h43, 32'h43,
                            32'h42, 32'h42};
    logic [31:0] es [5] = '{32'h0000007F, 32'hFFFFFF80,
                            32'h00000080, 32'hFFFF80F0,
                            32'h000080F0};
    for (int i = 0; i < 5; i++) begin
      run_txn(LD, fs[i], as[i], 32'h0, 3, 32'h80F07F01, o);
      total++;
      if (o.data !== es[i] || o.err !== 1'b0)
        $display("FAIL load%0d got %h e %b exp %h",
                 i, o.data, o.err, es[i]);
      else pass++;
      total++;
      if (o.lat != 5 || o.addr !== 32'h40 || o.we !== 1'b0)
        $display("FAIL load%0d_lat lat %0d a %h exp 5 40",
                 i, o.lat, o.addr);
      else pass++;
    end
  endtask

  task automatic test_errors();
    obs_t o;
    logic [6:0]  ops [4] = '{LD, LD, LD, ST};
    logic [2:0]  fs  [4] = '{3'd2, 3'd1, 3'd3, 3'd3};
    logic [31:0] as  [4] = '{32'h102, 32'h101,
                             32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      run_txn(ops[i], fs[i], as[i], 32'h1234, 0,
              32'hFFFFFFFF, o);
      total++;
      if (o.err !== 1'b1 || o.lat != 1 || o.data !== 0)
        $display("FAIL err%0d e %b lat %0d d %h exp 1 1 0",
                 i, o.err, o.lat, o.data);
      else pass++;
      total++;
      if (o.reqc != 0 || o.rdy !== 1'b1)
        $display("FAIL err%0d_noreq reqc %0d rdy %b exp 0 1",
                 i, o.reqc, o.rdy);
      else pass++;
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_txn(LD, 3'd2, 32'h80, 32'h0, -1, 32'h12345678, o);
    total++;
    if (o.reqc != TO || o.lat != TO + 1)
      $display("FAIL tmo_len reqc %0d lat %0d exp %0d %0d",
               o.reqc, o.lat, TO, TO + 1);
    else pass++;
    total++;
    if (o.err !== 1'b1 || o.data !== 32'd0)
      $display("FAIL tmo_resp e %b d %h exp 1 0",
               o.err, o.data);
    else pass++;
    run_txn(LD, 3'd2, 32'h80, 32'h0, TO - 1,
            32'h12345678, o);
    total++;
    if (o.err !== 1'b0 || o.data !== 32'h12345678)
      $display("FAIL tmo_ackwin e %b d %h exp 0 12345678",
               o.err, o.data);
    else pass++;
  endtask

  task automatic test_reset_mid();
    int bad;
    bif.mem_rdata = 32'hCAFEF00D;
    rif.req_valid = 1'b1;
    rif.opcode_in = LD;
    rif.funct3_in = 3'd2;
    rif.addr_in = 32'h300;
    tick();
    rif.req_valid = 1'b0;
    tick();
    total++;
    if (bif.mem_req !== 1'b1)
      $display("FAIL rmid_pre got %b exp 1", bif.mem_req);
    else pass++;
    rst = 1'b1;
    #1;
    total++;
    if (bif.mem_req !== 1'b0)
      $display("FAIL rmid_drop got %b exp 0", bif.mem_req);
    else pass++;
    @(negedge clk);
    rst = 1'b0;
    bif.mem_ack = 1'b1;
    tick();
    bif.mem_ack = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (rif.resp_valid !== 1'b0 || bif.mem_req !== 1'b0)
        bad++;
      tick();
    end
    total++;
    if (bad != 0)
      $display("FAIL rmid_late got %0d bad cycles exp 0", bad);
    else pass++;
    total++;
    if (rif.req_ready !== 1'b1)
      $display("FAIL rmid_ready got %b exp 1", rif.req_ready);
    else pass++;
  endtask

  task automatic test_nonmem();
    int bad;
    rif.req_valid = 1'b1;
    rif.opcode_in = 7'h33;
    rif.funct3_in = 3'd2;
    rif.addr_in = 32'h400;
    tick();
    rif.req_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (bif.mem_req !== 1'b0 || rif.resp_valid !== 1'b0 ||
          rif.req_ready !== 1'b1)
        bad++;
      tick();
    end
    total++;
    if (bad != 0)
      $display("FAIL nonmem got %0d bad cycles exp 0", bad);
    else pass++;
  endtask

  task automatic test_random();
    obs_t o;
    logic [2:0]  legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [6:0]  op;
    logic [2:0]  f;
    logic [31:0] a, d, rd, ed;
    int ack, el, er, ee;
    bit st;
    for (int i = 0; i < 60; i++) begin
      st = $urandom_range(0, 1) == 1;
      op = st ? ST : LD;
      if ($urandom_range(0, 4) == 0) f = 3'($urandom_range(0, 7));
      else f = legal[$urandom_range(0, 4)];
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      d = $urandom;
      rd = $urandom;
      ack = $urandom_range(0, 5) - 1;
      run_txn(op, f, a, d, ack, rd, o);
      if (m_bad(st, f, a)) begin
        ee = 1; ed = 0; el = 1; er = 0;
      end else if (ack < 0 || ack >= TO) begin
        ee = 1; ed = 0; el = TO + 1; er = TO;
      end else begin
        ee = 0; el = ack + 2; er = ack + 1;
        ed = st ? 32'd0 : m_load(f, a, rd);
      end
      total++;
      if (o.err !== 1'(ee) || o.data !== ed)
        $display("FAIL rnd%0d_resp e %b d %h exp %0d %h",
                 i, o.err, o.data, ee, ed);
      else pass++;
      total++;
      if (o.lat != el || o.reqc != er || o.rdy !== 1'b1)
        $display("FAIL rnd%0d_time lat %0d reqc %0d exp %0d %0d",
                 i, o.lat, o.reqc, el, er);
      else pass++;
      if (er > 0) begin
        total++;
        if (o.addr !== {a[31:2], 2'b00} || o.we !== 1'(st) ||
            o.stable !== 1'b1)
          $display("FAIL rnd%0d_bus a %h we %b st %b exp %h %0d",
                   i, o.addr, o.we, o.stable,
                   {a[31:2], 2'b00}, st);
        else pass++;
        total++;
        if (o.wdata !== (st ? m_wdata(f, d) : 32'd0) ||
            o.wstrb !== (st ? m_wstrb(f, a) : 4'd0))
          $display("FAIL rnd%0d_wr wd %h ws %b exp %h %b",
                   i, o.wdata, o.wstrb,
                   st ? m_wdata(f, d) : 32'd0,
                   st ? m_wstrb(f, a) : 4'd0);
        else pass++;
      end
    end
  endtask

  initial begin
    rif.req_valid = 1'b0;
    rif.opcode_in = '0;
    rif.funct3_in = '0;
    rif.addr_in = '0;
    rif.store_data_in = '0;
    bif.mem_rdata = '0;
    bif.mem_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_store();
    test_load();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_nonmem();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
